// File: rtl/exec_flag_pkg.sv
// Shared definitions for the execute-stage flag register and condition evaluator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package exec_flag_pkg;

    // Condition codes carried by branch and conditional-move requests
    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_EQ = 4'h1;
    localparam logic [3:0] CC_NE = 4'h2;
    localparam logic [3:0] CC_MI = 4'h3;
    localparam logic [3:0] CC_PL = 4'h4;
    localparam logic [3:0] CC_OV = 4'h5;
    localparam logic [3:0] CC_NO = 4'h6;
    localparam logic [3:0] CC_CS = 4'h7;
    localparam logic [3:0] CC_CC = 4'h8;
    localparam logic [3:0] CC_PS = 4'h9;
    localparam logic [3:0] CC_PC = 4'hA;
    localparam logic [3:0] CC_GE = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GT = 4'hD;
    localparam logic [3:0] CC_LE = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // Bit positions inside the packed flag vector {SF,OF,CF,PF,ZF}
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 0;

    // Request sequencer states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/exec_flag_cond_eval.sv
// Maps a condition code and a flag vector to a taken/not-taken decision.
// Latency: purely combinational.
// Backpressure: none; shared with the branch unit.
module exec_flag_cond_eval
    import exec_flag_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic [4:0] flags_i,
    output logic       taken_o
);

    logic sf;
    logic of;
    logic cf;
    logic pf;
    logic zf;

    assign sf = flags_i[FLAG_SF];
    assign of = flags_i[FLAG_OF];
    assign cf = flags_i[FLAG_CF];
    assign pf = flags_i[FLAG_PF];
    assign zf = flags_i[FLAG_ZF];

    // Decode the condition table; NV and anything unlisted is never taken
    always_comb begin
        taken_o = 1'b0;
        case (code_i)
            CC_AL:   taken_o = 1'b1;
            CC_EQ:   taken_o = zf;
            CC_NE:   taken_o = !zf;
            CC_MI:   taken_o = sf;
            CC_PL:   taken_o = !sf;
            CC_OV:   taken_o = of;
            CC_NO:   taken_o = !of;
            CC_CS:   taken_o = cf;
            CC_CC:   taken_o = !cf;
            CC_PS:   taken_o = pf;
            CC_PC:   taken_o = !pf;
            CC_GE:   taken_o = (sf == of);
            CC_LT:   taken_o = (sf != of);
            CC_GT:   taken_o = !zf && (sf == of);
            CC_LE:   taken_o = zf || (sf != of);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_flag_cond.sv
// Flag register plus condition evaluator that waits for all reserved flag writes to land.
// Latency: result strobe 1 cycle after acceptance when no writes pending, else 2 cycles after the last write.
// Backpressure: oRSV_BUSY when the reservation counter is full; oCC_BUSY while a request waits on pending writes.
module exec_flag_cond
    import exec_flag_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic       iFLUSH,
    input  logic       iRSV_VALID,
    output logic       oRSV_BUSY,
    input  logic       iWR_VALID,
    input  logic [4:0] iWR_MASK,
    input  logic [4:0] iWR_FLAGS,
    input  logic       iCC_REQ,
    input  logic [3:0] iCC_CODE,
    output logic       oCC_BUSY,
    output logic       oCC_VALID,
    output logic       oCC_TAKEN,
    output logic [4:0] oFLAGS
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [4:0]        flags_q,  flags_d;
    logic [PEND_W-1:0] pend_q,   pend_d;
    logic [0:0]        state_q,  state_d;
    logic [3:0]        code_q,   code_d;
    logic              vld_q,    vld_d;
    logic              taken_q,  taken_d;

    logic              rsv_acc;
    logic              can_eval;
    logic [3:0]        eval_code;
    logic              eval_taken;

    // A write landing this cycle frees a slot, so a full counter still accepts a reserve
    assign oRSV_BUSY = (pend_q == PEND_MAX) && !iWR_VALID;
    assign rsv_acc   = iRSV_VALID && !oRSV_BUSY;

    // Flags are only trustworthy once nothing is reserved and nothing is landing right now
    assign can_eval  = (pend_q == PEND_ZERO) && !iWR_VALID;
    assign eval_code = (state_q == ST_WAIT) ? code_q : iCC_CODE;

    exec_flag_cond_eval u_eval (
        .code_i  (eval_code),
        .flags_i (flags_q),
        .taken_o (eval_taken)
    );

    // Masked flag merge and reservation bookkeeping; flush clears reservations but keeps flags
    always_comb begin
        flags_d = flags_q;
        pend_d  = pend_q;
        if (iWR_VALID) begin
            flags_d = (flags_q & ~iWR_MASK) | (iWR_FLAGS & iWR_MASK);
        end
        if (iFLUSH) begin
            pend_d = PEND_ZERO;
        end else if (rsv_acc && !iWR_VALID) begin
            pend_d = pend_q + PEND_ONE;
        end else if (!rsv_acc && iWR_VALID && (pend_q != PEND_ZERO)) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // Request sequencer: answer immediately when flags are settled, otherwise park the code in WAIT
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        vld_d   = 1'b0;
        taken_d = taken_q;
        if (iFLUSH) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iCC_REQ) begin
                        if (can_eval) begin
                            vld_d   = 1'b1;
                            taken_d = eval_taken;
                        end else begin
                            code_d  = iCC_CODE;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (can_eval) begin
                        vld_d   = 1'b1;
                        taken_d = eval_taken;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Flag register and reservation counter
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            flags_q <= 5'b0;
            pend_q  <= PEND_ZERO;
        end else if (iRESET_SYNC) begin
            flags_q <= 5'b0;
            pend_q  <= PEND_ZERO;
        end else begin
            flags_q <= flags_d;
            pend_q  <= pend_d;
        end
    end

    // Sequencer state, parked code and result registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            code_q  <= 4'h0;
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
        end else if (iRESET_SYNC) begin
            state_q <= ST_IDLE;
            code_q  <= 4'h0;
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            taken_q <= taken_d;
        end
    end

    assign oFLAGS    = flags_q;
    assign oCC_BUSY  = (state_q == ST_WAIT);
    assign oCC_VALID = vld_q;
    assign oCC_TAKEN = taken_q;

endmodule

// File: doc/exec_flag_cond.md
# exec_flag_cond

Flag register and condition evaluator for the execute stage. Captures the SF/OF/CF/PF/ZF outputs produced by the execute units (logic, adder, shifter) and tracks in-flight flag producers with a reservation counter. Answers branch and conditional-move condition requests with a valid-pulsed taken/not-taken result, stalling each request until every reserved flag write has landed.

## Interface
Parameters:
- PEND_W, 2, width of the outstanding-write counter; maximum outstanding = 2^PEND_W-1 (3)

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear; same effect as reset
- iFLUSH  in  1  pipeline flush
- iRSV_VALID  in  1  issue stage reserves one future flag write
- oRSV_BUSY  out  1  counter full; reservation not accepted
- iWR_VALID  in  1  execute unit delivers flags
- iWR_MASK  in  5  per-flag write enable {SF,OF,CF,PF,ZF}
- iWR_FLAGS  in  5  flag values {SF,OF,CF,PF,ZF}
- iCC_REQ  in  1  condition request
- iCC_CODE  in  4  condition code
- oCC_BUSY  out  1  request not accepted this cycle
- oCC_VALID  out  1  one-cycle result strobe
- oCC_TAKEN  out  1  condition result, meaningful with oCC_VALID
- oFLAGS  out  5  current flag register {SF,OF,CF,PF,ZF}

## Operation
- Flag register: on iWR_VALID, each bit i with iWR_MASK[i]=1 takes iWR_FLAGS[i]; others hold.
- Pending counter: +1 on accepted reserve (iRSV_VALID && !oRSV_BUSY), -1 on iWR_VALID; both in one cycle → unchanged. Write with counter 0 still updates flags; counter stays 0 (no underflow). oRSV_BUSY = (counter == max) && !iWR_VALID.
- Condition codes: 0 AL(1); 1 EQ(ZF); 2 NE(!ZF); 3 MI(SF); 4 PL(!SF); 5 OV(OF); 6 NO(!OF); 7 CS(CF); 8 CC(!CF); 9 PS(PF); A PC(!PF); B GE(SF==OF); C LT(SF!=OF); D GT(!ZF&&SF==OF); E LE(ZF||SF!=OF); F NV(0).
- State machine IDLE/WAIT:
  - IDLE: oCC_BUSY=0. Request accepted. If counter==0 and !iWR_VALID: evaluate current oFLAGS, result registered → stay IDLE. Otherwise latch code → WAIT.
  - WAIT: oCC_BUSY=1. When counter==0 and !iWR_VALID: evaluate oFLAGS with latched code, register result → IDLE.
- iFLUSH (highest priority below reset): counter→0, WAIT→IDLE with no response, any result strobe due next cycle suppressed; flags hold; a simultaneous iWR_VALID still updates flags. A request in the same cycle as iFLUSH is dropped.
- iRESET_SYNC / inRESET: flags 0, counter 0, IDLE, all outputs 0.

## Timing
- Reset values: oFLAGS=0, oCC_VALID=0, oCC_TAKEN=0, oCC_BUSY=0, oRSV_BUSY=0.
- Flag write visible on oFLAGS one cycle after iWR_VALID.
- Request accepted at edge N with no pending writes → oCC_VALID/oCC_TAKEN at N+1, one cycle.
- Request with pending writes: oCC_VALID one cycle after the cycle in which counter==0 and no write occurs, i.e. 2 cycles after the last write.
- Back-to-back requests in IDLE supported, one result per cycle.
- oCC_TAKEN holds last value when oCC_VALID=0.

## Structure
- Shared package exec_flag_pkg: CC code localparams (CC_AL..CC_NV), flag bit indices (FLAG_SF=4 ... FLAG_ZF=0), state encoding.
- Sub-module exec_flag_cond_eval: combinational (code, flags) → taken; reused by the branch unit.

## Test plan
- Reset, then iWR_VALID mask 5'h1F flags 5'b00001 → oFLAGS=5'b00001 next cycle; CC EQ request → oCC_VALID at N+1, taken=1.
- Mask 5'b00100 flags 5'b11111 on flags 0 → oFLAGS=5'b00100 (only CF).
- Reserve twice, request GE → busy for cycles until second write of SF=1,OF=1; oCC_VALID 2 cycles after second write, taken=1.
- Three reservations → oRSV_BUSY=1; fourth held; reserve+write same cycle keeps counter 3.
- Request in WAIT, then iFLUSH → no oCC_VALID, counter 0, next request answered at N+1.
- All 16 codes against flags 0 and SF=1,OF=0,ZF=1 → matches table (e.g. LE=1, GT=0, NV=0, AL=1).
